adder_pipe: RTL and testbench

Parametrised, pipelined N-bit add/subtract unit with valid/ready flow control. The carry chain is split into STAGES equal segments. One segment is resolved per pipeline stage, so the block reaches full throughput at clock rates a single N-bit ripple chain cannot meet. It is the drop-in arithmetic core for datapaths that already carry valid/ready streams. It also adds subtract mode, signed overflow and backpressure.

---
 rtl/adder_pkg.sv | 15 +
 rtl/adder_seg.sv | 38 +++
 rtl/full_adder.sv | 13 +
 rtl/adder_pipe.sv | 142 ++++++++++++++
 tb/tb_adder_pipe.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined add/subtract unit.
package adder_pkg;

  // Operation mode carried alongside an accepted operand pair.
  typedef enum logic {
    ModeAdd = 1'b0,
    ModeSub = 1'b1
  } mode_e;

  // Width of one carry segment; callers guarantee n is a multiple of stages.
  function automatic int unsigned seg_width(input int unsigned n, input int unsigned stages);
    return n / stages;
  endfunction

endpackage

// File: rtl/adder_seg.sv
// Combinational W-bit ripple-carry segment. Besides the carry out it exposes the
// carry into its top bit so the most significant segment can derive signed overflow.
module adder_seg #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_c,
  output logic [W-1:0] o_sum,
  output logic         o_cout,
  output logic         o_cmsb
);

  // Per-bit carries live in their own generate scope so the chain stays a set of
  // independent scalars rather than one self-referencing vector.
  for (genvar i = 0; i < int'(W); i++) begin : g_bit
    logic w_ci;
    logic w_co;

    if (i == 0) begin : g_lsb
      assign w_ci = i_c;
    end else begin : g_chain
      assign w_ci = g_bit[i-1].w_co;
    end

    full_adder u_fa (
      .i_a (i_a[i]),
      .i_b (i_b[i]),
      .i_c (w_ci),
      .o_s (o_sum[i]),
      .o_c (w_co)
    );
  end

  assign o_cout = g_bit[W-1].w_co;
  assign o_cmsb = g_bit[W-1].w_ci;

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell, the building block of every carry segment.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));

endmodule

// File: rtl/adder_pipe.sv
// Pipelined N-bit add/subtract unit with valid/ready flow control. The carry chain is
// cut into STAGES equal segments; stage k resolves segment k using the carry that
// stage k-1 registered. Subtraction inverts b once at capture so the mode flag never
// travels down the pipe.
module adder_pipe import adder_pkg::*; #(
  parameter int unsigned N      = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int unsigned W = seg_width(N, STAGES);

  if (STAGES < 1 || STAGES > N || (N % STAGES) != 0) begin : g_bad_params
    $error("adder_pipe: N must be a non-zero multiple of STAGES");
  end

  // Stage payload. Operand slices below the current segment are already consumed
  // and sum slices above it are not yet produced; unused bits are pruned in synthesis.
  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] sum;
    logic         carry;
    logic         ovf;
  } stage_t;

  logic   r_valid    [STAGES];
  stage_t r_data     [STAGES];

  logic   w_ready    [STAGES];
  logic   w_vin      [STAGES];
  stage_t w_next     [STAGES];
  logic [W-1:0] w_op_a    [STAGES];
  logic [W-1:0] w_op_b    [STAGES];
  logic         w_op_c    [STAGES];
  logic [W-1:0] w_seg_sum [STAGES];
  logic         w_seg_cout[STAGES];
  logic         w_seg_cmsb[STAGES];

  mode_e        w_mode;
  logic [N-1:0] w_b_eff;

  // Decode mode and apply the subtract inversion to the whole b operand at capture.
  always_comb begin
    w_mode  = sub ? ModeSub : ModeAdd;
    w_b_eff = (w_mode == ModeSub) ? ~b : b;
  end

  // Select the operand slice and carry feeding each segment adder.
  always_comb begin
    w_op_a[0] = a[W-1:0];
    w_op_b[0] = w_b_eff[W-1:0];
    w_op_c[0] = (w_mode == ModeSub) ? 1'b1 : cin;
    w_vin[0]  = in_valid;
    for (int unsigned k = 1; k < STAGES; k++) begin
      w_op_a[k] = r_data[k-1].a[k*W +: W];
      w_op_b[k] = r_data[k-1].b[k*W +: W];
      w_op_c[k] = r_data[k-1].carry;
      w_vin[k]  = r_valid[k-1];
    end
  end

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_seg
    adder_seg #(
      .W (W)
    ) u_seg (
      .i_a    (w_op_a[k]),
      .i_b    (w_op_b[k]),
      .i_c    (w_op_c[k]),
      .o_sum  (w_seg_sum[k]),
      .o_cout (w_seg_cout[k]),
      .o_cmsb (w_seg_cmsb[k])
    );
  end

  // Build each stage's next payload: carry forward the upstream payload and merge
  // in the freshly resolved segment. Only the last segment produces a real ovf.
  always_comb begin
    w_next[0]                = '0;
    w_next[0].a              = a;
    w_next[0].b              = w_b_eff;
    w_next[0].sum[W-1:0]     = w_seg_sum[0];
    w_next[0].carry          = w_seg_cout[0];
    w_next[0].ovf            = (STAGES == 1) ? (w_seg_cmsb[0] ^ w_seg_cout[0]) : 1'b0;
    for (int unsigned k = 1; k < STAGES; k++) begin
      w_next[k]              = r_data[k-1];
      w_next[k].sum[k*W +: W] = w_seg_sum[k];
      w_next[k].carry        = w_seg_cout[k];
      w_next[k].ovf          = (k == STAGES - 1) ? (w_seg_cmsb[k] ^ w_seg_cout[k]) : 1'b0;
    end
  end

  // Ready chain from the output back to the input; an empty stage always accepts,
  // which lets bubbles collapse under backpressure.
  always_comb begin
    logic rdy;
    rdy = out_ready;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      w_ready[k] = !r_valid[k] || rdy;
      rdy        = w_ready[k];
    end
  end

  // Stage registers: advance when the stage can accept, otherwise hold everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        r_valid[k] <= 1'b0;
        r_data[k]  <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (w_ready[k]) begin
          r_valid[k] <= w_vin[k];
          if (w_vin[k]) begin
            r_data[k] <= w_next[k];
          end
        end
      end
    end
  end

  assign in_ready  = w_ready[0];
  assign out_valid = r_valid[STAGES-1];
  assign sum       = r_data[STAGES-1].sum;
  assign cout      = r_data[STAGES-1].carry;
  assign ovf       = r_data[STAGES-1].ovf;

endmodule

// File: tb/tb_adder_pipe.sv
// Scoreboard bench for adder_pipe: a 16-bit/4-stage instance with directed vectors,
// streaming, backpressure and mid-flight reset, plus three parameter-sweep instances.
module tb_adder_pipe;

  localparam int unsigned N = 16;
  localparam int unsigned S = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         sw_rst;
  logic         sweep_go;
  logic         in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [N-1:0] a, b, sum;
  int           cyc = 0;
  int           n_tests = 0;
  int           n_fail = 0;

  typedef struct {
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acc;
    bit           chk;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  // Cycle counter used to measure accept-to-output latency.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: {ovf, cout, sum} for an n-bit add/sub using the sign-rule overflow.
  function automatic logic [65:0] model(input int unsigned n, input logic [63:0] x,
                                        input logic [63:0] y, input logic c, input logic s);
    logic [63:0] mask, yy, r;
    logic [64:0] full;
    logic        co, ov;
    mask = (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
    yy   = (s ? ~y : y) & mask;
    full = {1'b0, x & mask} + {1'b0, yy} + {64'd0, (s ? 1'b1 : c)};
    r    = full[63:0] & mask;
    co   = full[n];
    ov   = (x[n-1] == yy[n-1]) && (r[n-1] != x[n-1]);
    return {ov, co, r};
  endfunction

  adder_pipe #(
    .N      (N),
    .STAGES (S)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  // Monitor: compare every delivered result against the scoreboard head.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_out: got sum 0x%0h, expected no output", sum);
      end else begin
        e = q.pop_front();
        check("result", 67'({sum, cout, ovf}), 67'({e.sum, e.cout, e.ovf}));
        if (e.chk) check("latency", 67'(cyc - e.acc), 67'(S));
      end
    end
  end

  // Offer one beat, wait (bounded) for the handshake and queue its expected result.
  task automatic send(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input logic tc,
                      input logic ts, input logic [N-1:0] es, input logic ec,
                      input logic eo, input bit chk);
    int   t;
    exp_t e;
    in_valid = 1'b1; a = ta; b = tb_v; cin = tc; sub = ts;
    t = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 50) begin
        n_tests++;
        n_fail++;
        $display("FAIL accept_timeout: got in_ready 0, expected 1 within 50 cycles");
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    e.sum = es; e.cout = ec; e.ovf = eo; e.acc = cyc; e.chk = chk;
    q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = N'($urandom); b = N'($urandom); cin = 1'($urandom); sub = 1'($urandom);
  endtask

  task automatic send_rand(input bit chk);
    logic [N-1:0] ta, tb_v;
    logic         tc, ts;
    logic [65:0]  r;
    ta = N'($urandom); tb_v = N'($urandom); tc = 1'($urandom); ts = 1'($urandom);
    r  = model(N, 64'(ta), 64'(tb_v), tc, ts);
    send(ta, tb_v, tc, ts, r[N-1:0], r[64], r[65], chk);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d results outstanding, expected 0", q.size());
      q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int acc_n;
    int t;
    logic [65:0] r;
    exp_t e;
    rst = 1'b1; sw_rst = 1'b1; sweep_go = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 67'(in_ready), 67'(1));
    check("rst_out_valid", 67'(out_valid), 67'(0));
    check("rst_outputs", 67'({sum, cout, ovf}), 67'(0));
    rst = 1'b0; sw_rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", 67'(in_ready), 67'(1));
    sweep_go = 1'b1;

    // Directed corners (a, b, cin, sub -> sum, cout, ovf).
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
    send(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1);
    send(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1);
    send(16'h00FF, 16'h0F00, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1);
    send(16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    send(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
    drain();

    // Back-to-back stream with the output always ready.
    for (int i = 0; i < 1000; i++) send_rand(1'b1);
    drain();

    // Fill under backpressure: exactly S accepts before in_ready falls.
    out_ready = 1'b0;
    acc_n = 0;
    t = 0;
    in_valid = 1'b1; a = N'($urandom); b = N'($urandom); cin = 1'($urandom);
    sub = 1'($urandom);
    while (t < 20) begin
      @(negedge clk);
      if (!in_ready) break;
      r = model(N, 64'(a), 64'(b), cin, sub);
      e.sum = r[N-1:0]; e.cout = r[64]; e.ovf = r[65]; e.acc = cyc; e.chk = 1'b0;
      q.push_back(e);
      acc_n++;
      t++;
      @(posedge clk); #1;
      a = N'($urandom); b = N'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    end
    check("fill_accepts", 67'(acc_n), 67'(S));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", 67'(in_ready), 67'(0));
      check("stall_out_valid", 67'(out_valid), 67'(1));
    end
    // Release with a beat pending: it must enter while the head leaves.
    @(posedge clk); #1;
    out_ready = 1'b1;
    #2;
    check("release_in_ready", 67'(in_ready), 67'(1));
    for (int i = 0; i < 3; i++) send_rand(1'b0);
    drain();

    // Reset with three beats in flight and the head already presented.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_rand(1'b0);
    @(posedge clk); #1;
    check("pre_rst_out_valid", 67'(out_valid), 67'(1));
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_out_valid", 67'(out_valid), 67'(0));
    check("rst_async_in_ready", 67'(in_ready), 67'(1));
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b1);
    drain();

    t = 0;
    while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done) && t < 5000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 5000) begin
      n_tests++;
      n_fail++;
      $display("FAIL sweep_timeout: got unfinished sweeps, expected all done");
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Parameter sweep: random add/sub against the model, latency must equal STAGES.
  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int unsigned SN = (g == 0) ? 8 : ((g == 1) ? 32 : 64);
    localparam int unsigned SS = (g == 0) ? 1 : ((g == 1) ? 8 : 2);

    typedef struct {
      logic [63:0] sum;
      logic        cout;
      logic        ovf;
      int          acc;
    } sexp_t;

    logic          s_iv, s_ir, s_cin, s_sub, s_ov, s_or, s_co, s_of;
    logic [SN-1:0] s_a, s_b, s_sum;
    bit            done = 1'b0;
    sexp_t         sq[$];

    adder_pipe #(
      .N      (SN),
      .STAGES (SS)
    ) u_dut (
      .clk       (clk),
      .rst       (sw_rst),
      .in_valid  (s_iv),
      .in_ready  (s_ir),
      .a         (s_a),
      .b         (s_b),
      .cin       (s_cin),
      .sub       (s_sub),
      .out_valid (s_ov),
      .out_ready (s_or),
      .sum       (s_sum),
      .cout      (s_co),
      .ovf       (s_of)
    );

    // Stimulus: one random beat per cycle, first beat is the all-ones + 1 corner.
    initial begin
      logic [65:0] r;
      sexp_t       e;
      int          t;
      s_iv = 1'b0; s_or = 1'b1; s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0;
      wait (sweep_go);
      @(posedge clk); #1;
      for (int i = 0; i < 150; i++) begin
        s_iv  = 1'b1;
        s_a   = SN'({$urandom, $urandom});
        s_b   = SN'({$urandom, $urandom});
        s_cin = 1'($urandom);
        s_sub = 1'($urandom);
        if (i == 0) begin
          s_a = '1; s_b = SN'(1); s_cin = 1'b0; s_sub = 1'b0;
        end
        @(negedge clk);
        if (s_ir) begin
          r = model(SN, 64'(s_a), 64'(s_b), s_cin, s_sub);
          e.sum = r[63:0]; e.cout = r[64]; e.ovf = r[65]; e.acc = cyc;
          sq.push_back(e);
        end else begin
          check($sformatf("sweep%0d_in_ready", g), 67'(s_ir), 67'(1));
        end
        @(posedge clk); #1;
      end
      s_iv = 1'b0;
      t = 0;
      while (sq.size() != 0 && t < 100) begin
        @(posedge clk);
        t++;
      end
      if (sq.size() != 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sweep%0d_drain: got %0d outstanding, expected 0", g, sq.size());
      end
      done = 1'b1;
    end

    // Sweep monitor.
    always @(negedge clk) begin : smon
      sexp_t e;
      if (!sw_rst && s_ov && s_or) begin
        if (sq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sweep%0d_unexpected: got sum 0x%0h, expected no output", g, s_sum);
        end else begin
          e = sq.pop_front();
          check($sformatf("sweep%0d_result", g), 67'({s_of, s_co, 64'(s_sum)}),
                67'({e.ovf, e.cout, e.sum}));
          check($sformatf("sweep%0d_latency", g), 67'(cyc - e.acc), 67'(SS));
        end
      end
    end
  end

endmodule
